// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
// The RxD line is brought into the clk domain with a two-flop synchronizer.
// A five-state FSM then times each bit from the falling edge of the start bit.
// The start bit is checked half a bit period in. Each data bit and the stop bit
// are sampled one full bit period after the previous sample point.
// A good frame updates data and pulses valid. A low stop bit pulses
// framing_error, and the FSM then waits in BREAK for the line to go high again.

module uart_rx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic          sync1_r;
  logic          sync2_r;
  logic          rx_s;

  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic [2:0]    idx_r;
  logic [2:0]    idx_next_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_next_s;
  logic [7:0]    data_r;
  logic [7:0]    data_next_s;
  logic          valid_r;
  logic          valid_next_s;
  logic          ferr_r;
  logic          ferr_next_s;
  logic          busy_r;
  logic          busy_next_s;

  // Two-flop synchronizer; idle-high reset so no false start bit appears after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= RxD;
      sync2_r <= sync1_r;
    end
  end

  assign rx_s = sync2_r;

  // Next-state, bit timing and strobe generation for the receive FSM.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r + CW'(1);
    idx_next_s   = idx_r;
    shift_next_s = shift_r;
    data_next_s  = data_r;
    valid_next_s = 1'b0;
    ferr_next_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cnt_next_s = {CW{1'b0}};
        if (rx_s == 1'b0) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_next_s = {CW{1'b0}};
          idx_next_s = 3'd0;
          if (rx_s == 1'b0) begin
            state_next_s = ST_DATA;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_START;
        end
      end

      ST_DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_next_s          = {CW{1'b0}};
          shift_next_s[idx_r] = rx_s;
          if (idx_r == 3'd7) begin
            state_next_s = ST_STOP;
            idx_next_s   = 3'd0;
          end else begin
            state_next_s = ST_DATA;
            idx_next_s   = idx_r + 3'd1;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end

      ST_STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_next_s = {CW{1'b0}};
          if (rx_s == 1'b1) begin
            data_next_s  = shift_r;
            valid_next_s = 1'b1;
            state_next_s = ST_IDLE;
          end else begin
            ferr_next_s  = 1'b1;
            state_next_s = ST_BREAK;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end

      ST_BREAK: begin
        // Hold here while the line stays low so a break yields no phantom frames.
        cnt_next_s = {CW{1'b0}};
        if (rx_s == 1'b1) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BREAK;
        end
      end

      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = {CW{1'b0}};
        idx_next_s   = 3'd0;
      end
    endcase

    busy_next_s = (state_next_s != ST_IDLE);
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      idx_r   <= idx_next_s;
      shift_r <= shift_next_s;
      data_r  <= data_next_s;
      valid_r <= valid_next_s;
      ferr_r  <= ferr_next_s;
      busy_r  <= busy_next_s;
    end
  end

  assign data          = data_r;
  assign valid         = valid_r;
  assign framing_error = ferr_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLKS_PER_BIT = 16.
// Expected bytes are pushed to a scoreboard queue as frames are sent. A monitor
// pops one entry on every valid strobe and compares it against data.

module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       busy;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;
  int valid_cnt  = 0;
  int ferr_cnt   = 0;
  logic valid_prev = 1'b0;

  logic [7:0] sb[$];
  int         valid_times[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .reset         (reset),
    .RxD           (RxD),
    .data          (data),
    .valid         (valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Bench cycle counter, used to time strobes.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pop on valid, strobe width and exclusivity checks.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (valid === 1'b1) begin
        valid_cnt++;
        valid_times.push_back(cyc);
        chk("valid_width", {31'd0, valid_prev}, 32'd0);
        chk("sb_has_entry", {31'd0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) chk("sb_data", {24'd0, data}, {24'd0, sb.pop_front()});
      end
      if (framing_error === 1'b1) ferr_cnt++;
      if (valid === 1'b1 || framing_error === 1'b1)
        chk("strobe_excl", {31'd0, valid & framing_error}, 32'd0);
    end
    valid_prev = valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame. t_start is the cycle on which the start bit was driven.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int t_start);
    t_start = cyc;
    RxD = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      step(CPB);
    end
    RxD = stop_bit;
    step(CPB);
  endtask

  initial begin
    int t;
    int t1;
    int t2;
    int k;
    logic bad;
    logic [7:0] part;

    // Reset-then-idle.
    reset = 1'b0;
    RxD   = 1'b1;
    step(5);
    chk("rst_data",  {24'd0, data}, 32'h00);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ferr",  {31'd0, framing_error}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    reset = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if ({data, valid, framing_error, busy} !== 11'd0) bad = 1'b1;
    end
    chk("idle_quiet", {31'd0, bad}, 32'd0);

    // Single good frame.
    sb.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, t);
    chk("single_valid_cnt",  valid_cnt, 32'd1);
    chk("single_valid_time", valid_times[0], t + 155);
    chk("single_data",       {24'd0, data}, 32'hA5);
    chk("single_ferr_cnt",   ferr_cnt, 32'd0);
    chk("single_busy_low",   {31'd0, busy}, 32'd0);

    // Back-to-back frames with no idle gap.
    sb.push_back(8'h00);
    send_byte(8'h00, 1'b1, t1);
    sb.push_back(8'hFF);
    send_byte(8'hFF, 1'b1, t2);
    step(2);
    chk("b2b_valid_cnt", valid_cnt, 32'd3);
    chk("b2b_t1",        valid_times[1], t1 + 155);
    chk("b2b_gap",       valid_times[2] - valid_times[1], 32'd160);
    chk("b2b_data",      {24'd0, data}, 32'hFF);

    // Framing error followed by a held-low break.
    sb.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, t);
    chk("fe_pre_data", {24'd0, data}, 32'hA5);
    send_byte(8'h3C, 1'b0, t);
    step(40);
    chk("fe_ferr_cnt",   ferr_cnt, 32'd1);
    chk("fe_valid_cnt",  valid_cnt, 32'd4);
    chk("fe_data_held",  {24'd0, data}, 32'hA5);
    chk("fe_busy_break", {31'd0, busy}, 32'd1);
    RxD = 1'b1;
    step(1);
    chk("fe_busy_sync",  {31'd0, busy}, 32'd1);
    step(4);
    chk("fe_busy_fall",  {31'd0, busy}, 32'd0);
    step(100);
    chk("fe_no_more_ferr",  ferr_cnt, 32'd1);
    chk("fe_no_more_valid", valid_cnt, 32'd4);

    // Glitch rejection: 4-cycle low pulse.
    RxD = 1'b0;
    step(4);
    RxD = 1'b1;
    chk("glitch_busy_rise", {31'd0, busy}, 32'd1);
    k = 0;
    while (busy !== 1'b0 && k < 12) begin
      step(1);
      k++;
    end
    chk("glitch_busy_fall", {31'd0, busy}, 32'd0);
    chk("glitch_fall_bound", {31'd0, (k <= 10)}, 32'd1);
    step(50);
    chk("glitch_valid_cnt", valid_cnt, 32'd4);
    chk("glitch_ferr_cnt",  ferr_cnt, 32'd1);

    // Mid-frame reset during data bit 3.
    part = 8'hC3;
    RxD = 1'b0;
    step(CPB);
    for (int i = 0; i < 3; i++) begin
      RxD = part[i];
      step(CPB);
    end
    RxD = part[3];
    step(CPB / 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_data",  {24'd0, data}, 32'h00);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_ferr",  {31'd0, framing_error}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    step(3);
    reset = 1'b1;
    RxD   = 1'b1;
    step(20);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    sb.push_back(8'h5A);
    send_byte(8'h5A, 1'b1, t);
    step(5);
    chk("post_rst_valid_cnt",  valid_cnt, 32'd5);
    chk("post_rst_valid_time", valid_times[4], t + 155);
    chk("post_rst_data",       {24'd0, data}, 32'h5A);
    chk("post_rst_ferr_cnt",   ferr_cnt, 32'd1);
    chk("sb_drained",          sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
